// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment decode table, segment bit positions and scan timing helper
package seven_seg_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction
  function automatic int slot_width(input int scan_div);
    return scan_div / 16;
  endfunction
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational hex nibble to active-high {g,f,e,d,c,b,a}
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = seg_decode(nibble);
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed seven-segment scanner with frame-synchronous double buffering
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs_en,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = slot_width(SCAN_DIV);
  logic [CW-1:0] slot_cnt;
  logic [DW-1:0] digit_idx;
  logic [NUM_DIGITS-1:0][3:0] pend_dig, disp_dig;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp, pend_blank, disp_blank, supp, onehot;
  logic pend_lzs, disp_lzs, slot_end, boundary, dark, lit, zeros_above;
  logic [6:0] seg_raw;
  assign slot_end = slot_cnt == CW'(SCAN_DIV - 1);
  assign boundary = slot_end && digit_idx == DW'(NUM_DIGITS - 1);
  // slot counter and digit index advance together; digit steps on slot wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) digit_idx <= boundary ? '0 : digit_idx + 1'b1;
    end
  // pending bank takes loads any time; display bank only refreshes at frame end so a frame never tears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lzs   <= 1'b0;
      disp_dig   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      disp_lzs   <= 1'b0;
    end else begin
      if (load) begin
        pend_dig   <= digits_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_lzs   <= lzs_en;
      end
      if (boundary) begin
        disp_dig   <= pend_dig;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        disp_lzs   <= pend_lzs;
      end
    end
  // a digit is suppressed while it and every digit above it are zero; digit 0 always shows
  always_comb begin
    supp        = '0;
    zeros_above = disp_lzs;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && disp_dig[i] == 4'h0;
      supp[i]     = zeros_above;
    end
  end
  seven_seg_decoder u_dec (
    .nibble(disp_dig[digit_idx]),
    .seg   (seg_raw)
  );
  assign dark   = disp_blank[digit_idx] | supp[digit_idx];
  assign lit    = !dark && int'(slot_cnt) < (int'(brightness) + 1) * SW;
  assign onehot = NUM_DIGITS'(1) << digit_idx;
  // registered pins with polarity applied last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg        <= {7{SEG_ACTIVE_LOW}};
      dp         <= SEG_ACTIVE_LOW;
      an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= (dark ? 7'h00 : seg_raw) ^ {7{SEG_ACTIVE_LOW}};
      dp         <= (!dark && disp_dp[digit_idx]) ^ SEG_ACTIVE_LOW;
      an         <= (lit ? onehot : '0) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done <= boundary;
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed and random scan checks against a time-indexed display model
module tb_seven_seg_scan_driver;
  logic clk, rst_n, load, lzs_en, dp, frame_done;
  logic [23:0] digits_in;
  logic [5:0] dp_in, blank_in, an;
  logic [3:0] brightness;
  logic [6:0] seg;
  int n_checks = 0;
  int n_fail = 0;
  seven_seg_scan_driver #(
    .NUM_DIGITS(6), .SCAN_DIV(16), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lzs_en(lzs_en), .brightness(brightness), .seg(seg),
    .dp(dp), .an(an), .frame_done(frame_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int t, ms, md, mtop;
  bit mdark;
  logic [3:0] m_pend [6];
  logic [3:0] m_disp [6];
  logic [5:0] mp_dp, md_dp, mp_bl, md_bl, exp_an;
  logic mp_lzs, md_lzs, exp_dp, exp_fd;
  logic [6:0] exp_seg;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask
  // model: t counts cycles since reset release; digit = t/16 mod 6, slot position = t mod 16
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < 6; i++) begin
        m_pend[i] = 4'h0;
        m_disp[i] = 4'h0;
      end
      {mp_dp, md_dp, mp_bl, md_bl, mp_lzs, md_lzs} = '0;
      {exp_an, exp_seg, exp_dp, exp_fd} = '0;
    end else begin
      ms = t % 16;
      md = (t / 16) % 6;
      mtop = 0;
      for (int i = 0; i < 6; i++) if (m_disp[i] != 4'h0) mtop = i;
      mdark = md_bl[md] || (md_lzs && md > mtop);
      exp_seg = mdark ? 7'h00 : lut[m_disp[md]];
      exp_dp = !mdark && md_dp[md];
      exp_an = (!mdark && ms < (int'(brightness) + 1) * (16 / 16)) ? 6'(1 << md) : 6'd0;
      exp_fd = (t % 96) == 95;
      if ((t % 96) == 95) begin
        for (int i = 0; i < 6; i++) m_disp[i] = m_pend[i];
        md_dp = mp_dp;
        md_bl = mp_bl;
        md_lzs = mp_lzs;
      end
      if (load) begin
        for (int i = 0; i < 6; i++) m_pend[i] = digits_in[4*i +: 4];
        mp_dp = dp_in;
        mp_bl = blank_in;
        mp_lzs = lzs_en;
      end
      t++;
    end
  always @(negedge clk) begin
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
  end
  task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b, input logic l);
    digits_in = d;
    dp_in = p;
    blank_in = b;
    lzs_en = l;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_phase(input int ph);
    for (int i = 0; i < 200 && (t % 96) != ph; i++) @(negedge clk);
  endtask
  initial begin
    logic [23:0] v;
    int zk;
    rst_n = 1'b0;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    blank_in = '0;
    lzs_en = 1'b0;
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    repeat (37) @(negedge clk);
    do_load(24'h12345F, 6'b000100, 6'b0, 1'b0);
    repeat (200) @(negedge clk);
    do_load(24'h000070, 6'b0, 6'b0, 1'b1);
    repeat (200) @(negedge clk);
    do_load(24'h000070, 6'b0, 6'b0, 1'b0);
    repeat (200) @(negedge clk);
    wait_phase(95);
    repeat (3) @(negedge clk);
    do_load(24'h111111, 6'b0, 6'b0, 1'b0);
    repeat (5) @(negedge clk);
    do_load(24'h222222, 6'b0, 6'b0, 1'b0);
    wait_phase(95);
    do_load(24'h333333, 6'b0, 6'b0, 1'b0);
    repeat (250) @(negedge clk);
    brightness = 4'd3;
    repeat (200) @(negedge clk);
    brightness = 4'd0;
    repeat (200) @(negedge clk);
    brightness = 4'd15;
    do_load(24'h0A0B0C, 6'b101010, 6'b010000, 1'b0);
    repeat (100) @(negedge clk);
    wait_phase(50);
    do_load(24'hABCDEF, 6'b111111, 6'b0, 1'b0);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      load = ($urandom % 25) == 0;
      if (load) begin
        zk = $urandom % 7;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = (i >= 6 - zk) ? 4'h0 : 4'($urandom % 16);
        digits_in = v;
        dp_in = 6'($urandom);
        blank_in = ($urandom % 3 == 0) ? 6'($urandom) : 6'd0;
        lzs_en = 1'($urandom);
      end
      if ($urandom % 80 == 0) brightness = 4'($urandom);
      if ($urandom % 1500 == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
    repeat (100) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
